// File: rtl/sdram_port_mux.sv
// sdram_port_mux: arbitrates NPORTS Wishbone-style 16-bit masters onto the
// single level-sensitive we/rd/ready sdram controller interface. Also owns
// controller init sequencing, the sticky ready flag and a WAIT watchdog.
module sdram_port_mux #(
  parameter int NPORTS     = 2,
  parameter int AW         = 21,
  parameter int INIT_DELAY = 3,
  parameter int RR         = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk_p,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    wb_stb,
  input  logic [NPORTS-1:0]    wb_we,
  input  logic [2*NPORTS-1:0]  wb_sel,
  input  logic [AW*NPORTS-1:0] wb_adr,
  input  logic [16*NPORTS-1:0] wb_dat_i,
  output logic [15:0]          wb_dat_o,
  output logic [NPORTS-1:0]    wb_ack,
  output logic                 sdr_init,
  output logic                 sdr_we,
  output logic                 sdr_rd,
  output logic [1:0]           sdr_wtbt,
  output logic [24:0]          sdr_addr,
  output logic [15:0]          sdr_din,
  input  logic [15:0]          sdr_dout,
  input  logic                 sdr_ready,
  output logic                 sdram_ready,
  output logic                 timeout_flag,
  output logic [2:0]           grant
);

  localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int ICW = $clog2(INIT_DELAY + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_ACK} state_t;

  state_t           state, state_nxt;
  logic [ICW-1:0]   init_cnt;
  logic [WCW-1:0]   wcnt;
  logic             lat_we;
  logic [PW-1:0]    win, cand, gidx;
  logic             win_vld;
  logic             wait_expired;

  logic [1:0]       sel_a [NPORTS];
  logic [AW-1:0]    adr_a [NPORTS];
  logic [15:0]      dat_a [NPORTS];

  // Unpack the flat per-master buses into per-port arrays.
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign sel_a[p] = wb_sel[2*p +: 2];
    assign adr_a[p] = wb_adr[AW*p +: AW];
    assign dat_a[p] = wb_dat_i[16*p +: 16];
  end

  assign gidx         = grant[PW-1:0];
  assign wait_expired = (wcnt == WCW'(TIMEOUT - 1));

  // Init sequencer: hold sdr_init through reset, then for INIT_DELAY cycles.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      init_cnt <= '0;
      sdr_init <= 1'b1;
    end else if (sdr_init) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == ICW'(INIT_DELAY - 1)) sdr_init <= 1'b0;
    end
  end

  // Sticky "controller finished init" flag; gates all arbitration.
  always_ff @(posedge clk_p) begin
    if (reset) sdram_ready <= 1'b0;
    else if (!sdr_init && sdr_ready) sdram_ready <= 1'b1;
  end

  // Winner search: fixed priority from port 0, or rotating from grant+1.
  always_comb begin
    win     = '0;
    cand    = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      if (RR != 0) cand = PW'((int'(grant) + 1 + k) % NPORTS);
      else         cand = PW'(k);
      if (!win_vld && wb_stb[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_p) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus command/ack outputs. REQ never looks at sdr_ready, since
  // the controller may still be showing ready from the previous transaction.
  always_comb begin
    state_nxt = state;
    sdr_we    = 1'b0;
    sdr_rd    = 1'b0;
    wb_ack    = '0;
    case (state)
      ST_IDLE: if (sdram_ready && win_vld) state_nxt = ST_REQ;
      ST_REQ: begin
        sdr_we    = lat_we;
        sdr_rd    = !lat_we;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        sdr_we = lat_we;
        sdr_rd = !lat_we;
        if (sdr_ready || wait_expired) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        // A master that dropped its strobe mid-flight is not acked.
        if (wb_stb[gidx]) wb_ack[gidx] = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch the winner in IDLE, count WAIT cycles, capture read data.
  // Ready beats the watchdog when both land in the same cycle.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      grant        <= '0;
      lat_we       <= 1'b0;
      sdr_wtbt     <= '0;
      sdr_addr     <= '0;
      sdr_din      <= '0;
      wb_dat_o     <= '0;
      timeout_flag <= 1'b0;
      wcnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: if (sdram_ready && win_vld) begin
          grant    <= 3'(win);
          lat_we   <= wb_we[win];
          sdr_wtbt <= wb_we[win] ? sel_a[win] : 2'b00;
          sdr_addr <= 25'(adr_a[win]) << 1;
          sdr_din  <= dat_a[win];
        end
        ST_REQ: wcnt <= '0;
        ST_WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (sdr_ready) begin
            if (!lat_we) wb_dat_o <= sdr_dout;
          end else if (wait_expired) begin
            wb_dat_o     <= 16'hFFFF;
            timeout_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sdram_port_mux.md
# sdram_port_mux

Multi-master front end for the board-level `sdram` controller.
- Arbitrates NPORTS Wishbone-style 16-bit masters (CPU bus, DMA, video fetch) onto the single level-sensitive we/rd/ready controller interface.
- Takes over, in parametrised form, the init-delay sequencing, ready flag and delayed-ack generation that the board top currently builds for one master.
- Adds round-robin arbitration, stale-ready masking and a watchdog timeout.
- Sits between the `TOPBOARD` kernel and `sdram` in every board top.

## Interface
Parameters:
- NPORTS, 2: number of masters, 1..8; port 0 has the highest fixed priority.
- AW, 21: word address width; master address bits are [AW:1]; AW ≤ 24.
- INIT_DELAY, 3: cycles `sdr_init` stays high after reset drops, ≥ 1.
- RR, 1: 0 = fixed priority, 1 = round-robin.
- TIMEOUT, 255: maximum WAIT cycles before forced completion, ≥ 4.

Ports:
- clk_p  in  1  system clock, 100 MHz; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_stb  in  NPORTS  request strobe, one bit per master.
- wb_we  in  NPORTS  1 = write.
- wb_sel  in  2*NPORTS  byte selects; port p uses bits [2p+1:2p].
- wb_adr  in  AW*NPORTS  word address; port p uses slice p.
- wb_dat_i  in  16*NPORTS  write data; port p uses slice p.
- wb_dat_o  out  16  read data, shared by all masters; valid only with that master's ack.
- wb_ack  out  NPORTS  one-cycle acknowledge per master.
- sdr_init  out  1  controller init request.
- sdr_we  out  1  controller write command.
- sdr_rd  out  1  controller read command.
- sdr_wtbt  out  2  byte enables to the controller.
- sdr_addr  out  25  byte address {zero pad, adr[AW:1], 1'b0}.
- sdr_din  out  16  write data to the controller.
- sdr_dout  in  16  read data from the controller.
- sdr_ready  in  1  controller done/idle.
- sdram_ready  out  1  sticky flag: controller has completed init.
- timeout_flag  out  1  sticky flag: a transaction timed out.
- grant  out  3  index of the current or last-granted port.

## Operation
Init sequencer:
- While `reset` is high: `sdr_init` = 1 and the init counter is cleared.
- After `reset` falls, the counter runs for INIT_DELAY cycles; `sdr_init` then drops to 0.
- `sdram_ready` clears on reset and sets on the first cycle with `sdr_init` = 0 and `sdr_ready` = 1.
- No grant is issued until `sdram_ready` = 1.

FSM states:
- IDLE
  - If `sdram_ready` and any `wb_stb` is high, select the winner.
    - RR=0: lowest asserted index wins.
    - RR=1: search starts at `grant`+1 (mod NPORTS) and wraps.
  - Latch the winner's we, sel, adr and dat_i; set `grant`; go to REQ.
- REQ (exactly 1 cycle)
  - Assert `sdr_we` or `sdr_rd` from the latched we.
  - `sdr_ready` is ignored in this cycle: the previous transaction's ready may still be high.
  - Go to WAIT.
- WAIT
  - Hold the command.
  - On `sdr_ready` = 1: for a read, capture `sdr_dout` into `wb_dat_o`; go to ACK.
  - If the wait counter reaches TIMEOUT: set `wb_dat_o` = 16'hFFFF, set `timeout_flag`, go to ACK.
- ACK (1 cycle)
  - Command outputs return to 0.
  - `wb_ack[grant]` = 1, but only if `wb_stb[grant]` is still high; an aborted master gets no ack, and its write is still performed.
  - Go to IDLE.

Data-path rules:
- `sdr_addr`, `sdr_din` and `sdr_wtbt` come from the latched values and stay stable from REQ through ACK.
- `sdr_wtbt` = latched sel for writes and 2'b00 for reads.
- Masters must drop `wb_stb` on the clock edge that ends their ack cycle. The FSM returns to IDLE on that same edge, so a stale strobe is never re-granted.

## Timing
- Reset values: `sdr_init`=1; `sdr_we`, `sdr_rd`, `wb_ack`, `sdram_ready`, `timeout_flag`=0; `sdr_wtbt`=0; `sdr_addr`, `sdr_din`, `wb_dat_o`, `grant`=0; FSM in IDLE.
- Minimum latency from `wb_stb` to `wb_ack`: 4 cycles (IDLE, REQ, WAIT with ready, ACK).
- Back-to-back transactions from different masters: one IDLE cycle between them.
- Reset asserted mid-transaction: on the next edge all outputs return to reset values and the FSM goes to IDLE. No ack is issued and the init sequence restarts.
- Simultaneous ready and timeout in the same cycle: ready wins; real data is returned and `timeout_flag` is not set.
- The `grant` counter wraps NPORTS-1 → 0.

## Test plan
- Init: reset high 5 cycles, then low; `sdr_ready` held 1 → `sdr_init` falls exactly INIT_DELAY=3 cycles after reset drops; `sdram_ready` rises 1 cycle later.
- Stale ready: read port 0 at adr 21'h000010 while `sdr_ready` is still 1 from the previous op, and the model returns 16'h1234 three cycles into WAIT → ack arrives only after the REQ cycle, with `wb_dat_o`=16'h1234 and `sdr_addr`=25'h0000020.
- Round-robin: NPORTS=3, all strobes held continuously → grants go 0,1,2,0,…; with RR=0 → port 0 every time.
- Byte write: port 1 writes sel=2'b10, data 16'hAB00 → `sdr_we` high REQ through WAIT, `sdr_wtbt`=2'b10, `sdr_din`=16'hAB00, ack on port 1 only.
- Timeout and abort:
  - Controller never asserts ready → ack after TIMEOUT cycles with 16'hFFFF, and `timeout_flag`=1.
  - Master drops stb during WAIT → no ack.
- Reset during WAIT → commands drop on the next edge, no ack, `sdr_init` reasserts.
